// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle capture of decode with writeback bypass, load-use detection,
// flush/stall handling (flush > stall > load-use bubble > load); async active-low reset clears all state.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs,
    input  logic [ADDR_WIDTH-1:0] id_rt,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  id_mem_read,
    input  logic                  wb_wr_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    output logic                  ex_mem_read,
    output logic [ADDR_WIDTH-1:0] ex_rs,
    output logic [ADDR_WIDTH-1:0] ex_rt,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0] ex_rs_data,
    output logic [DATA_WIDTH-1:0] ex_rt_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic                  load_use_stall
);

    logic                  ex_valid_q, ex_valid_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic [ADDR_WIDTH-1:0] ex_rs_q, ex_rs_d;
    logic [ADDR_WIDTH-1:0] ex_rt_q, ex_rt_d;
    logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_WIDTH-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_WIDTH-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_WIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [CTRL_WIDTH-1:0] ex_ctrl_q, ex_ctrl_d;

    logic                  wb_hit_ok;
    logic [DATA_WIDTH-1:0] id_rs_byp, id_rt_byp;

    // Register 0 is hardwired, so a write to it must never be forwarded.
    assign wb_hit_ok = wb_wr_en && (wb_addr != '0);
    assign id_rs_byp = (wb_hit_ok && (wb_addr == id_rs)) ? wb_data : id_rs_data;
    assign id_rt_byp = (wb_hit_ok && (wb_addr == id_rt)) ? wb_data : id_rt_data;

    assign load_use_stall = ex_valid_q && ex_mem_read_q && id_valid && (ex_rt_q != '0) &&
                            ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_mem_read_d = ex_mem_read_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_rd_d       = ex_rd_q;
        ex_rs_data_d  = ex_rs_data_q;
        ex_rt_data_d  = ex_rt_data_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        if (flush || (!stall && load_use_stall)) begin
            ex_valid_d    = 1'b0;
            ex_mem_read_d = 1'b0;
            ex_rs_d       = '0;
            ex_rt_d       = '0;
            ex_rd_d       = '0;
            ex_rs_data_d  = '0;
            ex_rt_data_d  = '0;
            ex_imm_d      = '0;
            ex_ctrl_d     = '0;
        end else if (stall) begin
            // A held instruction must still observe writebacks that retire while it waits.
            if (ex_valid_q && wb_hit_ok && (wb_addr == ex_rs_q))
                ex_rs_data_d = wb_data;
            if (ex_valid_q && wb_hit_ok && (wb_addr == ex_rt_q))
                ex_rt_data_d = wb_data;
        end else begin
            ex_valid_d    = id_valid;
            ex_mem_read_d = id_valid && id_mem_read;
            ex_rs_d       = id_rs;
            ex_rt_d       = id_rt;
            ex_rd_d       = id_rd;
            ex_rs_data_d  = id_rs_byp;
            ex_rt_data_d  = id_rt_byp;
            ex_imm_d      = id_imm;
            ex_ctrl_d     = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ex_valid_q    <= 1'b0;
            ex_mem_read_q <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_mem_read = ex_mem_read_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs_data  = ex_rs_data_q;
    assign ex_rt_data  = ex_rt_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, operand width; ADDR_WIDTH, default 5, register address width; CTRL_WIDTH, default 12, opaque control bundle width.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 n_reset  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  global hold request from downstream memory.
REQ-005 flush  in  1  branch/jump squash of the instruction in decode.
REQ-006 id_valid  in  1  decode slot holds a real instruction.
REQ-007 id_rs, id_rt, id_rd  in  ADDR_WIDTH each  decode register addresses.
REQ-008 id_rs_data, id_rt_data  in  DATA_WIDTH each  combinational register-file read data.
REQ-009 id_imm  in  DATA_WIDTH  sign-extended immediate.
REQ-010 id_ctrl  in  CTRL_WIDTH  decoded control bundle.
REQ-011 id_mem_read  in  1  decode instruction is a load.
REQ-012 wb_wr_en, wb_addr, wb_data  in  1 / ADDR_WIDTH / DATA_WIDTH  writeback port, identical to the register-file write port.
REQ-013 ex_valid, ex_mem_read  out  1 each  registered slot-valid and load flag.
REQ-014 ex_rs, ex_rt, ex_rd  out  ADDR_WIDTH each  registered addresses.
REQ-015 ex_rs_data, ex_rt_data, ex_imm  out  DATA_WIDTH each  registered operands.
REQ-016 ex_ctrl  out  CTRL_WIDTH  registered control bundle.
REQ-017 load_use_stall  out  1  combinational request for upstream to hold PC and IF/ID.

Function
REQ-018 load_use_stall SHALL be ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-019 Write-through bypass: an operand SHALL take wb_data instead of register-file data when wb_wr_en = 1, wb_addr != 0 and wb_addr equals that operand's source address; rs and rt SHALL be evaluated independently.
REQ-020 Register address 0 SHALL never be bypassed.
REQ-021 Per-edge priority SHALL be flush > stall > load_use_stall > load.
REQ-022 Flush (regardless of stall): ex_valid, ex_mem_read and ex_ctrl SHALL become 0; the other fields are don't-care and SHALL be cleared to 0.
REQ-023 Stall without flush: all outputs SHALL hold, except that a held ex_rs_data/ex_rt_data SHALL be replaced by wb_data when ex_valid = 1, wb_wr_en = 1, wb_addr != 0 and wb_addr equals ex_rs/ex_rt.
REQ-024 Load-use without stall or flush: a bubble SHALL be inserted, with the same register values as a flush; the decode instruction is re-presented next cycle by upstream.
REQ-025 Otherwise all id_* fields SHALL be captured, with bypass applied, and ex_valid SHALL equal id_valid.
REQ-026 When id_valid = 0, ex_ctrl and ex_mem_read SHALL be captured as 0.
REQ-027 Latency SHALL be exactly one clock from decode inputs to ex_* outputs; there is no combinational path from id_* to ex_*.
REQ-028 load_use_stall SHALL depend only on ex_* state and the id_rs, id_rt and id_valid inputs.

Reset
REQ-029 While n_reset = 0, every ex_* output SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Reset asserted mid-stall or mid-bubble SHALL discard the held instruction.
REQ-031 The first edge after reset release SHALL follow REQ-021 normally.

Verification
REQ-032 Plain capture: id_valid = 1, rs = 3 with data 0x11, rt = 4 with data 0x22, no writeback -> next edge ex_rs_data = 0x11, ex_rt_data = 0x22, ex_valid = 1.
REQ-033 Bypass: id_rs = 7, id_rs_data = 0x5, wb_wr_en = 1, wb_addr = 7, wb_data = 0xABCD -> ex_rs_data = 0xABCD; repeat with both addresses 0 -> the register-file value passes.
REQ-034 Load-use: EX holds a load with rt = 9, decode has rs = 9 -> load_use_stall = 1, next edge ex_valid = 0; on the following edge the instruction enters with ex_valid = 1.
REQ-035 Stall with writeback: stall = 1, ex_rt = 5, wb writes 5 = 0x77 -> ex_rt_data = 0x77 and all other fields unchanged.
REQ-036 Priority and reset: flush = 1 and stall = 1 together -> bubble; n_reset pulsed low between edges -> all outputs 0 asynchronously.
